// File: rtl/ai_i2s_pkg.sv
// Shared types and defaults for the I2S transmit path.
// Sample width and resolution width here must agree with the I2S clock generator.
package ai_i2s_pkg;

  localparam int I2S_DATA_WIDTH = 32;
  localparam int I2S_RES_WIDTH  = 6;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

  typedef struct packed {
    logic [I2S_DATA_WIDTH-1:0] left;
    logic [I2S_DATA_WIDTH-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/ai_i2s_sync_fifo.sv
// Single-clock frame FIFO with a registered occupancy count and no write-to-read bypass.
// DEPTH must be a power of two so that the pointers wrap without extra logic.
module ai_i2s_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == LW'(0));
  assign level = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ai_i2s_tx_serializer.sv
// Master-mode I2S transmitter: buffers stereo frames and shifts them out MSB-first,
// one bit per SCK falling-edge strobe, with the standard one-SCK delay after each WS edge.
module ai_i2s_tx_serializer
  import ai_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int RES_WIDTH  = I2S_RES_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [RES_WIDTH-1:0]          resolution,
  input  logic                          clk_en,
  input  logic                          ws_in,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_left,
  input  logic [DATA_WIDTH-1:0]         s_right,
  input  logic                          underrun_clr,
  output logic                          i2s_sd,
  output logic                          underrun,
  output logic                          underrun_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FW = 2 * DATA_WIDTH;

  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic [FW-1:0]         fifo_rdata_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  i2s_ch_e               ws_q, ws_d;
  logic                  load_pend_q, load_pend_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [RES_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  sd_q, sd_d;
  logic                  underrun_q, underrun_d;
  logic                  underrun_flag_q, underrun_flag_d;
  logic                  ws_change_s;
  logic                  res_zero_s;

  assign s_ready     = ~fifo_full_s;
  assign fifo_push_s = s_valid & ~fifo_full_s;

  ai_i2s_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata ({s_left, s_right}),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Slot controller: WS edge tracking, slot loads, bit shifting and underrun detection.
  always_comb begin
    ws_d            = ws_q;
    load_pend_d     = load_pend_q;
    shift_d         = shift_q;
    hold_d          = hold_q;
    bit_cnt_d       = bit_cnt_q;
    sd_d            = sd_q;
    underrun_d      = 1'b0;
    fifo_pop_s      = 1'b0;
    ws_change_s     = (ws_in != ws_q);
    res_zero_s      = (resolution == {RES_WIDTH{1'b0}});
    if (!enable) begin
      ws_d        = CH_LEFT;
      load_pend_d = 1'b0;
      shift_d     = '0;
      hold_d      = '0;
      bit_cnt_d   = '0;
      sd_d        = 1'b0;
    end else begin
      ws_d = i2s_ch_e'(ws_in);
      if (clk_en) begin
        // A WS change seen on this same strobe re-arms the load for the next strobe.
        load_pend_d = ws_change_s;
        if (res_zero_s) begin
          sd_d = 1'b0;
        end else if (load_pend_q) begin
          if (ws_q == CH_LEFT) begin
            if (!fifo_empty_s) begin
              fifo_pop_s = 1'b1;
              shift_d    = fifo_rdata_s[FW-1:DATA_WIDTH];
              hold_d     = fifo_rdata_s[DATA_WIDTH-1:0];
            end else begin
              shift_d    = '0;
              hold_d     = '0;
              underrun_d = 1'b1;
            end
          end else begin
            shift_d = hold_q;
          end
          sd_d      = shift_d[DATA_WIDTH-1];
          bit_cnt_d = RES_WIDTH'(1);
        end else if (bit_cnt_q < resolution) begin
          shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
          sd_d      = shift_d[DATA_WIDTH-1];
          bit_cnt_d = bit_cnt_q + RES_WIDTH'(1);
        end else begin
          sd_d = 1'b0;
        end
      end else begin
        load_pend_d = load_pend_q | ws_change_s;
      end
    end
    if (underrun_d) begin
      underrun_flag_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_flag_d = 1'b0;
    end else begin
      underrun_flag_d = underrun_flag_q;
    end
  end

  // Serializer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q            <= CH_LEFT;
      load_pend_q     <= 1'b0;
      shift_q         <= '0;
      hold_q          <= '0;
      bit_cnt_q       <= '0;
      sd_q            <= 1'b0;
      underrun_q      <= 1'b0;
      underrun_flag_q <= 1'b0;
    end else begin
      ws_q            <= ws_d;
      load_pend_q     <= load_pend_d;
      shift_q         <= shift_d;
      hold_q          <= hold_d;
      bit_cnt_q       <= bit_cnt_d;
      sd_q            <= sd_d;
      underrun_q      <= underrun_d;
      underrun_flag_q <= underrun_flag_d;
    end
  end

  assign i2s_sd        = sd_q;
  assign underrun      = underrun_q;
  assign underrun_flag = underrun_flag_q;

endmodule

// File: tb/tb_ai_i2s_tx_serializer.sv
// Randomized bench for ai_i2s_tx_serializer: a behavioural clock-generator stand-in drives
// clk_en/WS, and a slot-level reference model predicts every output cycle by cycle.
module tb_ai_i2s_tx_serializer;
  import ai_i2s_pkg::*;

  localparam int DW = 32;
  localparam int RW = 6;
  localparam int FD = 4;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [RW-1:0] resolution;
  logic          clk_en;
  logic          ws_in;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;
  logic          underrun_clr;
  logic          i2s_sd;
  logic          underrun;
  logic          underrun_flag;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  ai_i2s_tx_serializer #(.DATA_WIDTH(DW), .RES_WIDTH(RW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .resolution(resolution),
    .clk_en(clk_en), .ws_in(ws_in), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .underrun_clr(underrun_clr),
    .i2s_sd(i2s_sd), .underrun(underrun), .underrun_flag(underrun_flag),
    .fifo_level(fifo_level)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame queue plus the word of the current slot and its bit index.
  stereo_frame_t m_q[$];
  bit            m_pend, m_prev_ws;
  logic [DW-1:0] m_word, m_right;
  int            m_k;
  bit            m_sd, m_und, m_flag;

  // Clock-generator stand-in.
  int g_div, g_sck;
  bit g_ws, g_tog;

  function automatic bit slot_bit(input logic [DW-1:0] w, input int k, input int res);
    if (k < res && k < DW) return w[DW-1-k];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend = 0; m_prev_ws = 0; m_word = '0; m_right = '0; m_k = 0;
    m_sd = 0; m_und = 0; m_flag = 0;
    g_div = 0; g_sck = 0; g_ws = 0; g_tog = 0;
  endtask

  task automatic tick();
    bit            push;
    bit            ws_changed;
    stereo_frame_t f;
    int            res;
    res  = int'(resolution);
    push = s_valid && (m_q.size() != FD);
    if (!enable) begin
      m_pend = 0; m_prev_ws = 0; m_word = '0; m_right = '0; m_k = 0; m_sd = 0; m_und = 0;
    end else begin
      ws_changed = (ws_in != m_prev_ws);
      m_und = 0;
      if (clk_en) begin
        if (res == 0) begin
          m_sd = 0;
        end else if (m_pend) begin
          if (!m_prev_ws) begin
            if (m_q.size() > 0) begin
              f = m_q.pop_front();
              m_word = f.left; m_right = f.right;
            end else begin
              m_word = '0; m_right = '0; m_und = 1;
            end
          end else begin
            m_word = m_right;
          end
          m_k  = 0;
          m_sd = slot_bit(m_word, 0, res);
        end else begin
          if (m_k < 1000) m_k++;
          m_sd = slot_bit(m_word, m_k, res);
        end
      end
      m_pend    = ws_changed ? 1'b1 : (clk_en ? 1'b0 : m_pend);
      m_prev_ws = ws_in;
    end
    if (m_und) m_flag = 1;
    else if (underrun_clr) m_flag = 0;
    if (push) m_q.push_back({s_left, s_right});
    @(posedge clk);
    #1;
    check_eq("sd", 64'(i2s_sd), 64'(m_sd));
    check_eq("underrun", 64'(underrun), 64'(m_und));
    check_eq("underrun_flag", 64'(underrun_flag), 64'(m_flag));
    check_eq("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check_eq("s_ready", 64'(s_ready), 64'(m_q.size() != FD));
  endtask

  // clr_mode: 0 never, 1 random, 2 forced.
  task automatic drive(input bit en, input bit pause, input int ratio, input int res,
                       input int pv, input bit fixed, input logic [DW-1:0] fl,
                       input logic [DW-1:0] fr, input int clr_mode);
    bit ce;
    ce = 0;
    if (!en) begin
      g_div = 0; g_sck = 0; g_ws = 0; g_tog = 0;
    end else if (!pause) begin
      if (g_tog) begin g_ws = ~g_ws; g_tog = 0; end
      ce    = (g_div == 0);
      g_div = (g_div >= ratio) ? 0 : g_div + 1;
      if (ce) begin
        g_sck++;
        if (g_sck >= res) begin g_sck = 0; g_tog = 1; end
      end
    end
    enable       = en;
    clk_en       = ce;
    ws_in        = g_ws;
    resolution   = RW'(res);
    s_valid      = ($urandom_range(0, 99) < pv);
    s_left       = fixed ? fl : $urandom;
    s_right      = fixed ? fr : $urandom;
    underrun_clr = (clr_mode == 2) || (clr_mode == 1 && $urandom_range(0, 99) < 3);
    tick();
  endtask

  task automatic run(input int n, input bit en, input int ratio, input int res, input int pv,
                     input bit fixed, input logic [DW-1:0] fl, input logic [DW-1:0] fr,
                     input int clr_mode);
    for (int i = 0; i < n; i++) drive(en, 1'b0, ratio, res, pv, fixed, fl, fr, clr_mode);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; resolution = '0; clk_en = 1'b0; ws_in = 1'b0;
    s_valid = 1'b0; s_left = '0; s_right = '0; underrun_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_sd", 64'(i2s_sd), 64'd0);
    check_eq("rst_underrun", 64'(underrun), 64'd0);
    check_eq("rst_flag", 64'(underrun_flag), 64'd0);
    check_eq("rst_level", 64'(fifo_level), 64'd0);
    check_eq("rst_ready", 64'(s_ready), 64'd1);
    rst_n = 1'b1;

    // Enabled with nothing queued: every left slot underruns, flag stays sticky.
    run(300, 1'b1, 1, 16, 0, 1'b0, '0, '0, 0);
    check_eq("flag_sticky", 64'(underrun_flag), 64'd1);
    run(2, 1'b0, 1, 16, 0, 1'b0, '0, '0, 2);
    check_eq("flag_cleared", 64'(underrun_flag), 64'd0);

    // Single known frame at resolution 16, SCK every clk.
    run(3, 1'b0, 0, 16, 0, 1'b0, '0, '0, 0);
    run(1, 1'b1, 0, 16, 100, 1'b1, 32'hA5A5_0000, 32'h3C3C_0000, 0);
    run(120, 1'b1, 0, 16, 0, 1'b0, '0, '0, 0);

    // Fill the FIFO with the strobe paused, then let one left slot pop.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 0, 16, 100, 1'b0, '0, '0, 0);
    check_eq("full_level", 64'(fifo_level), 64'd4);
    check_eq("full_ready", 64'(s_ready), 64'd0);
    run(200, 1'b1, 0, 16, 100, 1'b0, '0, '0, 0);

    // Resolution wider than the sample: zero padding after 32 bits.
    run(3, 1'b0, 1, 40, 0, 1'b0, '0, '0, 1);
    run(600, 1'b1, 1, 40, 40, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1);

    // Drop enable mid-stream with frames queued, then resume.
    run(3, 1'b0, 2, 24, 0, 1'b0, '0, '0, 0);
    run(150, 1'b1, 2, 24, 30, 1'b0, '0, '0, 0);
    run(20, 1'b0, 2, 24, 10, 1'b0, '0, '0, 0);
    run(300, 1'b1, 2, 24, 20, 1'b0, '0, '0, 0);

    // Heavy traffic at a short slot: frequent push and pop in the same clk.
    run(3, 1'b0, 0, 4, 0, 1'b0, '0, '0, 0);
    run(400, 1'b1, 0, 4, 70, 1'b0, '0, '0, 1);

    // Resolution 0: sd quiet, no pops and no underruns.
    run(3, 1'b0, 0, 0, 0, 1'b0, '0, '0, 0);
    run(100, 1'b1, 1, 0, 50, 1'b0, '0, '0, 0);

    // Random configurations.
    for (int p = 0; p < 6; p++) begin
      int ratio, res, pv;
      ratio = $urandom_range(0, 3);
      res   = $urandom_range(1, 40);
      pv    = $urandom_range(5, 90);
      run(3, 1'b0, ratio, res, 0, 1'b0, '0, '0, 0);
      run(500, 1'b1, ratio, res, pv, 1'b0, '0, '0, 1);
    end

    // Asynchronous reset between clock edges.
    run(5, 1'b1, 0, 8, 100, 1'b0, '0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_level", 64'(fifo_level), 64'd0);
    check_eq("async_rst_ready", 64'(s_ready), 64'd1);
    check_eq("async_rst_sd", 64'(i2s_sd), 64'd0);
    model_reset();
    enable = 1'b0; s_valid = 1'b0; clk_en = 1'b0; ws_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(100, 1'b1, 0, 8, 50, 1'b0, '0, '0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
